// File: rtl/tone_pkg.sv
// Shared constants and width helpers for the polyphonic tone generator.
package tone_pkg;

    // Ceiling log2 that can be evaluated at elaboration time; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of the voice-select field; at least one bit even for a single voice.
    function automatic int sel_width(input int num_voices);
        return (clog2(num_voices) < 1) ? 1 : clog2(num_voices);
    endfunction

    // Width of the mixed level: enough to hold every voice at full volume.
    function automatic int mix_width(input int num_voices, input int volume_width);
        return volume_width + clog2(num_voices + 1);
    endfunction

    // Mixed level that corresponds to a modulator output of constant 1.
    function automatic int full_scale(input int num_voices, input int volume_width);
        return num_voices * ((1 << volume_width) - 1);
    endfunction

    // Notes of the middle octave, for sequencers that want symbolic pitches.
    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_C4   = 4'd1,
        NOTE_D4   = 4'd2,
        NOTE_E4   = 4'd3,
        NOTE_F4   = 4'd4,
        NOTE_G4   = 4'd5,
        NOTE_A4   = 4'd6,
        NOTE_B4   = 4'd7,
        NOTE_C5   = 4'd8
    } note_e;

    // Half-period in cycles of the 33 MHz clock: 33e6 / (2 * f), rounded.
    localparam int HP_C4 = 63067;
    localparam int HP_D4 = 56187;
    localparam int HP_E4 = 50057;
    localparam int HP_F4 = 47247;
    localparam int HP_G4 = 42092;
    localparam int HP_A4 = 37500;
    localparam int HP_B4 = 33409;
    localparam int HP_C5 = 31534;

    // Map a symbolic note to the half-period value a voice expects (0 = silent).
    function automatic int note_half_period(input note_e note);
        int hp;
        case (note)
            NOTE_C4: hp = HP_C4;
            NOTE_D4: hp = HP_D4;
            NOTE_E4: hp = HP_E4;
            NOTE_F4: hp = HP_F4;
            NOTE_G4: hp = HP_G4;
            NOTE_A4: hp = HP_A4;
            NOTE_B4: hp = HP_B4;
            NOTE_C5: hp = HP_C5;
            default: hp = 0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: pending/active half-period, cycle counter, phase and volume.
// A new period only takes effect at the next toggle edge so the waveform never
// glitches; a silent voice (active period 0) picks up a new period immediately.
module tone_voice
    import tone_pkg::*;
#(
    parameter int PERIOD_WIDTH = 24,
    parameter int VOLUME_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wr_en,
    input  logic [PERIOD_WIDTH-1:0] i_wr_period,
    input  logic [VOLUME_WIDTH-1:0] i_wr_volume,
    output logic                    o_phase,
    output logic [VOLUME_WIDTH-1:0] o_volume
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

    logic [PERIOD_WIDTH-1:0] r_pending;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic                    r_phase;
    logic [VOLUME_WIDTH-1:0] r_volume;

    // A write landing on the same cycle as an edge must be used at that edge.
    logic [PERIOD_WIDTH-1:0] w_pending_eff;
    logic                    w_silent;
    logic                    w_edge;
    logic                    w_next_silent;

    assign w_pending_eff = i_wr_en ? i_wr_period : r_pending;
    assign w_silent      = (r_period == '0);
    assign w_edge        = !w_silent && (r_cnt == (r_period - PERIOD_ONE));
    assign w_next_silent = (w_pending_eff == '0);

    // Register writes, counter advance and period hand-over at the toggle edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
            r_period  <= '0;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_volume  <= '0;
        end else begin
            if (i_wr_en) begin
                r_pending <= i_wr_period;
                r_volume  <= i_wr_volume;
            end
            if (w_silent) begin
                // Silent voice: start fresh from phase 0 as soon as a period exists.
                r_period <= w_pending_eff;
                r_cnt    <= '0;
                r_phase  <= 1'b0;
            end else if (w_edge) begin
                // Toggle edge; switching to silence parks the phase low.
                r_period <= w_pending_eff;
                r_cnt    <= '0;
                r_phase  <= w_next_silent ? 1'b0 : ~r_phase;
            end else begin
                r_cnt <= r_cnt + PERIOD_ONE;
            end
        end
    end

    assign o_phase  = r_phase;
    assign o_volume = r_volume;

endmodule

// File: rtl/poly_tone_generator.sv
// Polyphonic square-wave generator: write decode into NUM_VOICES voices, a
// registered volume mix, and a first-order sigma-delta modulator that drives
// the 1-bit piezo/audio pin.
module poly_tone_generator
    import tone_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int PERIOD_WIDTH = 24,
    parameter int VOLUME_WIDTH = 4
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst_n,
    input  logic                                                i_output_enable,
    input  logic                                                i_wr_en,
    input  logic [sel_width(NUM_VOICES)-1:0]                    i_wr_voice,
    input  logic [PERIOD_WIDTH-1:0]                             i_wr_period,
    input  logic [VOLUME_WIDTH-1:0]                             i_wr_volume,
    output logic [NUM_VOICES-1:0]                               o_voice_phase,
    output logic [mix_width(NUM_VOICES, VOLUME_WIDTH)-1:0]      o_mix_level,
    output logic                                                o_square_wave_out
);

    localparam int SEL_W = sel_width(NUM_VOICES);
    localparam int MIX_W = mix_width(NUM_VOICES, VOLUME_WIDTH);
    localparam int FULL  = full_scale(NUM_VOICES, VOLUME_WIDTH);

    // Accumulator is one bit wider than the mix: acc < FULL and mix <= FULL,
    // so acc + mix < 2*FULL always fits.
    localparam logic [MIX_W:0] FULL_V = FULL[MIX_W:0];

    logic [NUM_VOICES-1:0]   w_wr_hit;
    logic [NUM_VOICES-1:0]   w_phase;
    logic [VOLUME_WIDTH-1:0] w_volume [NUM_VOICES];
    logic [MIX_W-1:0]        w_mix_sum;
    logic [MIX_W:0]          w_sd_sum;
    logic                    w_sd_fire;

    logic [MIX_W-1:0]        r_mix;
    logic [MIX_W:0]          r_acc;
    logic                    r_out;

    // Out-of-range voice indices never match any decode line, so they are ignored.
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign w_wr_hit[gi] = i_wr_en && (i_wr_voice == SEL_W'(gi));

            tone_voice #(
                .PERIOD_WIDTH (PERIOD_WIDTH),
                .VOLUME_WIDTH (VOLUME_WIDTH)
            ) u_voice (
                .i_clk       (i_clk),
                .i_rst_n     (i_rst_n),
                .i_wr_en     (w_wr_hit[gi]),
                .i_wr_period (i_wr_period),
                .i_wr_volume (i_wr_volume),
                .o_phase     (w_phase[gi]),
                .o_volume    (w_volume[gi])
            );
        end
    endgenerate

    // Sum the volumes of voices whose square wave is currently high.
    always_comb begin
        w_mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_phase[v]) begin
                w_mix_sum = w_mix_sum + MIX_W'(w_volume[v]);
            end
        end
    end

    // Mix register: one cycle after a phase change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mix <= '0;
        end else begin
            r_mix <= w_mix_sum;
        end
    end

    assign w_sd_sum  = r_acc + {1'b0, r_mix};
    assign w_sd_fire = (w_sd_sum >= FULL_V);

    // Sigma-delta modulator; disabled output parks the accumulator at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_out <= 1'b0;
        end else if (!i_output_enable) begin
            r_acc <= '0;
            r_out <= 1'b0;
        end else if (w_sd_fire) begin
            r_acc <= w_sd_sum - FULL_V;
            r_out <= 1'b1;
        end else begin
            r_acc <= w_sd_sum;
            r_out <= 1'b0;
        end
    end

    assign o_voice_phase     = w_phase;
    assign o_mix_level       = r_mix;
    assign o_square_wave_out = r_out;

endmodule

// File: tb/tb_poly_tone_generator.sv
// Randomized bench for poly_tone_generator (5 voices, so voice indices 5..7 are
// out of range) against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_poly_tone_generator;

    localparam int NV   = 5;
    localparam int PW   = 24;
    localparam int VW   = 4;
    localparam int SW   = 3;
    localparam int MW   = 7;
    localparam int FULL = NV * 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          oe;
    logic          wr_en;
    logic [SW-1:0] wr_voice;
    logic [PW-1:0] wr_period;
    logic [VW-1:0] wr_volume;
    logic [NV-1:0] voice_phase;
    logic [MW-1:0] mix_level;
    logic          sq_out;

    int total = 0;
    int bad   = 0;

    // Reference model: each voice remembers the cycle number of its next toggle.
    int    m_pend  [NV];
    int    m_per   [NV];
    int    m_vol   [NV];
    int    m_phase [NV];
    longint m_next [NV];
    int    m_mix;
    int    m_acc;
    int    m_out;
    longint cyc;

    always #15.15 clk = ~clk;

    poly_tone_generator #(
        .NUM_VOICES   (NV),
        .PERIOD_WIDTH (PW),
        .VOLUME_WIDTH (VW)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_output_enable   (oe),
        .i_wr_en           (wr_en),
        .i_wr_voice        (wr_voice),
        .i_wr_period       (wr_period),
        .i_wr_volume       (wr_volume),
        .o_voice_phase     (voice_phase),
        .o_mix_level       (mix_level),
        .o_square_wave_out (sq_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_pend[v]  = 0;
            m_per[v]   = 0;
            m_vol[v]   = 0;
            m_phase[v] = 0;
            m_next[v]  = 0;
        end
        m_mix = 0;
        m_acc = 0;
        m_out = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int new_mix;
        int s;
        int pend;
        new_mix = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_phase[v] != 0) new_mix += m_vol[v];
        end
        if (!oe) begin
            m_out = 0;
            m_acc = 0;
        end else begin
            s = m_acc + m_mix;
            if (s >= FULL) begin
                m_out = 1;
                m_acc = s - FULL;
            end else begin
                m_out = 0;
                m_acc = s;
            end
        end
        m_mix = new_mix;
        for (int v = 0; v < NV; v++) begin
            pend = m_pend[v];
            if (wr_en && (int'(wr_voice) == v)) begin
                pend      = int'(wr_period);
                m_pend[v] = pend;
                m_vol[v]  = int'(wr_volume);
            end
            if (m_per[v] == 0) begin
                m_per[v]   = pend;
                m_phase[v] = 0;
                m_next[v]  = cyc + pend;
            end else if (cyc == m_next[v]) begin
                m_per[v]   = pend;
                m_phase[v] = (pend == 0) ? 0 : 1 - m_phase[v];
                m_next[v]  = cyc + pend;
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        logic [NV-1:0] ev;
        for (int v = 0; v < NV; v++) ev[v] = (m_phase[v] != 0);
        chk("phase", 32'(voice_phase), 32'(ev));
        chk("mix",   32'(mix_level),   32'(m_mix));
        chk("out",   32'(sq_out),      32'(m_out));
    endtask

    // One clock: model and DUT step together, outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic write_voice(input int v, input int p, input int vol);
        wr_en     = 1'b1;
        wr_voice  = SW'(v);
        wr_period = PW'(p);
        wr_volume = VW'(vol);
        step();
        wr_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_phase"}, 32'(voice_phase), 32'd0);
        chk({tag, "_mix"},   32'(mix_level),   32'd0);
        chk({tag, "_out"},   32'(sq_out),      32'd0);
    endtask

    initial begin
        int ones;
        int mix_sum;
        int diff;

        cyc       = 0;
        rst_n     = 1'b0;
        oe        = 1'b1;
        wr_en     = 1'b0;
        wr_voice  = '0;
        wr_period = '0;
        wr_volume = '0;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two audible voices, density of 1s tracks the mix.
        write_voice(0, 3, 15);
        write_voice(1, 5, 15);
        ones    = 0;
        mix_sum = 0;
        for (int n = 0; n < 60; n++) begin
            mix_sum += m_mix;
            step();
            if (sq_out) ones++;
        end
        diff = ones * FULL - mix_sum;
        chk("density", 32'((diff <= FULL) && (diff >= -FULL)), 32'd1);

        // Period change mid half-period and at the last count; silence and restart.
        write_voice(0, 10, 9);
        repeat (14) step();
        write_voice(0, 2, 9);
        repeat (30) step();
        write_voice(1, 0, 15);
        repeat (12) step();
        write_voice(1, 6, 7);
        repeat (20) step();

        // Out-of-range voice indices must not disturb anything.
        write_voice(7, 1, 15);
        write_voice(5, 2, 3);
        write_voice(6, 0, 0);
        repeat (10) step();

        // Output disabled for a stretch, then re-enabled.
        oe = 1'b0;
        repeat (20) step();
        oe = 1'b1;
        repeat (20) step();

        // Randomized writes, including writes landing on toggle edges.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) oe = ~oe;
            if ($urandom_range(0, 7) == 0) begin
                wr_en     = 1'b1;
                wr_voice  = SW'($urandom_range(0, 7));
                wr_period = ($urandom_range(0, 5) == 0) ? '0 : PW'($urandom_range(1, 12));
                wr_volume = VW'($urandom_range(0, 15));
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;

        // Asynchronous reset between clock edges while notes are playing.
        oe = 1'b1;
        write_voice(2, 4, 12);
        repeat (9) step();
        #5;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();

        // Life after reset: state must start clean.
        write_voice(3, 3, 15);
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                wr_en     = 1'b1;
                wr_voice  = SW'($urandom_range(0, 7));
                wr_period = PW'($urandom_range(0, 8));
                wr_volume = VW'($urandom_range(0, 15));
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
